// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes an RV32I instruction into an ALU command,
// selects and extends operands A/B, and holds the result in a single-entry
// pipeline register with valid/ready handshaking and flush support.
module id_ex_alu_issue #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_A,
  output logic [DATA_WIDTH-1:0] out_B,
  output logic [3:0]            out_ALUctr,
  output logic [4:0]            out_rd,
  output logic                  out_rd_we,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic                  out_illegal
);

  // ALU command codes shared with the EX stage
  localparam logic [3:0] ALU_CTRL_ADD    = 4'd0;
  localparam logic [3:0] ALU_CTRL_SUB    = 4'd1;
  localparam logic [3:0] ALU_CTRL_SLL    = 4'd2;
  localparam logic [3:0] ALU_CTRL_SLT    = 4'd3;
  localparam logic [3:0] ALU_CTRL_SLTU   = 4'd4;
  localparam logic [3:0] ALU_CTRL_XOR    = 4'd5;
  localparam logic [3:0] ALU_CTRL_SLR    = 4'd6;
  localparam logic [3:0] ALU_CTRL_SAR    = 4'd7;
  localparam logic [3:0] ALU_CTRL_OR     = 4'd8;
  localparam logic [3:0] ALU_CTRL_AND    = 4'd9;
  localparam logic [3:0] ALU_CTRL_COPY_B = 4'd10;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_rs1_field;

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt;

  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [3:0]            dec_ctr;
  logic                  dec_we;
  logic                  dec_ill;

  logic transfer;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // The rs1 index is consumed by the register file, not by this stage
  assign unused_rs1_field = ^inst[19:15];

  assign imm_i = DATA_WIDTH'($signed(inst[31:20]));
  assign imm_s = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
  assign imm_u = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
  assign shamt = DATA_WIDTH'(inst[24:20]);

  // Single-entry register: room whenever empty or being drained this cycle
  assign in_ready = !out_valid || out_ready;
  assign transfer = in_valid && in_ready;

  // Combinational decode of the incoming instruction into an ALU command
  always_comb begin
    dec_a   = '0;
    dec_b   = '0;
    dec_ctr = ALU_CTRL_ADD;
    dec_we  = 1'b0;
    dec_ill = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        dec_b   = imm_u;
        dec_ctr = ALU_CTRL_COPY_B;
        dec_we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a  = pc;
        dec_b  = imm_u;
        dec_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_a  = pc;
        dec_b  = DATA_WIDTH'(4);
        dec_we = 1'b1;
      end
      OPC_LOAD: begin
        dec_a  = rs1_data;
        dec_b  = imm_i;
        dec_we = 1'b1;
      end
      OPC_STORE: begin
        dec_a = rs1_data;
        dec_b = imm_s;
      end
      OPC_BRANCH: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        case (funct3)
          3'b000, 3'b001: dec_ctr = ALU_CTRL_SUB;
          3'b100, 3'b101: dec_ctr = ALU_CTRL_SLT;
          3'b110, 3'b111: dec_ctr = ALU_CTRL_SLTU;
          default:        dec_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_a  = rs1_data;
        dec_b  = imm_i;
        dec_we = 1'b1;
        case (funct3)
          3'b000: dec_ctr = ALU_CTRL_ADD;
          3'b010: dec_ctr = ALU_CTRL_SLT;
          3'b011: dec_ctr = ALU_CTRL_SLTU;
          3'b100: dec_ctr = ALU_CTRL_XOR;
          3'b110: dec_ctr = ALU_CTRL_OR;
          3'b111: dec_ctr = ALU_CTRL_AND;
          3'b001: begin
            dec_b = shamt;
            if (funct7 == F7_BASE) dec_ctr = ALU_CTRL_SLL;
            else                   dec_ill = 1'b1;
          end
          default: begin
            dec_b = shamt;
            if (funct7 == F7_BASE)     dec_ctr = ALU_CTRL_SLR;
            else if (funct7 == F7_ALT) dec_ctr = ALU_CTRL_SAR;
            else                       dec_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec_a  = rs1_data;
        dec_b  = rs2_data;
        dec_we = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec_ctr = ALU_CTRL_ADD;
            3'b001:  dec_ctr = ALU_CTRL_SLL;
            3'b010:  dec_ctr = ALU_CTRL_SLT;
            3'b011:  dec_ctr = ALU_CTRL_SLTU;
            3'b100:  dec_ctr = ALU_CTRL_XOR;
            3'b101:  dec_ctr = ALU_CTRL_SLR;
            3'b110:  dec_ctr = ALU_CTRL_OR;
            default: dec_ctr = ALU_CTRL_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_ctr = ALU_CTRL_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_ctr = ALU_CTRL_SAR;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    // An undecodable word must not disturb the datapath or the register file
    if (dec_ill) begin
      dec_a   = '0;
      dec_b   = '0;
      dec_ctr = ALU_CTRL_ADD;
      dec_we  = 1'b0;
    end
    // x0 is hard-wired to zero, so never request a write to it
    if (rd == 5'd0) dec_we = 1'b0;
  end

  // Pipeline register: reset beats flush, flush beats transfer, and the
  // payload only changes when a new instruction is actually accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_A       <= '0;
      out_B       <= '0;
      out_pc      <= '0;
      out_rd      <= '0;
      out_ALUctr  <= ALU_CTRL_ADD;
      out_rd_we   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid   <= 1'b1;
      out_A       <= dec_a;
      out_B       <= dec_b;
      out_pc      <= pc;
      out_rd      <= rd;
      out_ALUctr  <= dec_ctr;
      out_rd_we   <= dec_we;
      out_illegal <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed instruction vectors,
// a behavioural reference model compared every cycle, and literal checks.
module tb_id_ex_alu_issue;

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_SLL  = 4'd2;
  localparam logic [3:0] C_SLT  = 4'd3;
  localparam logic [3:0] C_SLTU = 4'd4;
  localparam logic [3:0] C_XOR  = 4'd5;
  localparam logic [3:0] C_SLR  = 4'd6;
  localparam logic [3:0] C_SAR  = 4'd7;
  localparam logic [3:0] C_OR   = 4'd8;
  localparam logic [3:0] C_AND  = 4'd9;
  localparam logic [3:0] C_CPB  = 4'd10;
  localparam logic [3:0] C_BAD  = 4'd15;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctr;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [3:0]  out_ALUctr;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks;
  int errors;

  // Reference state: what the stage must be holding
  logic m_valid;
  logic m_pristine;
  cmd_t m_cmd;
  logic cmp_en;

  id_ex_alu_issue #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_ALUctr(out_ALUctr), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-set meaning of a word, expressed as operand sources and tables
  function automatic cmd_t model_decode(input logic [31:0] w, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
    cmd_t c;
    logic [3:0] br_tbl [8];
    logic [3:0] imm_tbl [8];
    logic [3:0] op_tbl [16];
    logic [31:0] ii, si, ui, sh;
    logic [3:0] sel;
    br_tbl  = '{C_SUB, C_SUB, C_BAD, C_BAD, C_SLT, C_SLT, C_SLTU, C_SLTU};
    imm_tbl = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SLR, C_OR, C_AND};
    op_tbl  = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SLR, C_OR, C_AND,
                C_SUB, C_BAD, C_BAD, C_BAD, C_BAD, C_SAR, C_BAD, C_BAD};
    ii = {{20{w[31]}}, w[31:20]};
    si = {{20{w[31]}}, w[31:25], w[11:7]};
    ui = {w[31:12], 12'h000};
    sh = {27'd0, w[24:20]};
    c = '0;
    c.rd = w[11:7];
    c.pc = p;
    sel = C_BAD;
    if (w[6:0] == 7'h37) begin c.b = ui; sel = C_CPB; c.we = 1; end
    else if (w[6:0] == 7'h17) begin c.a = p; c.b = ui; sel = C_ADD; c.we = 1; end
    else if (w[6:0] == 7'h6F || w[6:0] == 7'h67) begin c.a = p; c.b = 4; sel = C_ADD; c.we = 1; end
    else if (w[6:0] == 7'h03) begin c.a = r1; c.b = ii; sel = C_ADD; c.we = 1; end
    else if (w[6:0] == 7'h23) begin c.a = r1; c.b = si; sel = C_ADD; end
    else if (w[6:0] == 7'h63) begin c.a = r1; c.b = r2; sel = br_tbl[w[14:12]]; end
    else if (w[6:0] == 7'h13) begin
      c.a = r1; c.we = 1;
      if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
        c.b = sh;
        if (w[31:25] == 7'h00) sel = imm_tbl[w[14:12]];
        else if (w[31:25] == 7'h20 && w[14:12] == 3'd5) sel = C_SAR;
      end else begin
        c.b = ii; sel = imm_tbl[w[14:12]];
      end
    end else if (w[6:0] == 7'h33) begin
      c.a = r1; c.b = r2; c.we = 1;
      if (w[31:25] == 7'h00) sel = op_tbl[{1'b0, w[14:12]}];
      else if (w[31:25] == 7'h20) sel = op_tbl[{1'b1, w[14:12]}];
    end
    if (sel == C_BAD) begin
      c.a = 0; c.b = 0; c.ctr = C_ADD; c.we = 0; c.ill = 1;
    end else begin
      c.ctr = sel;
    end
    if (c.rd == 0) c.we = 0;
    return c;
  endfunction

  // Reference handshake/state behaviour, evaluated at each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      m_pristine <= 1'b1;
      m_cmd      <= '{a: 0, b: 0, ctr: C_ADD, rd: 0, we: 0, ill: 0, pc: 0};
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid    <= 1'b1;
      m_pristine <= 1'b0;
      m_cmd      <= model_decode(inst, pc, rs1_data, rs2_data);
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison of the DUT against the reference model
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (out_valid !== m_valid || in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("[TB] FAIL model_hs: out_valid=%0b in_ready=%0b expected out_valid=%0b in_ready=%0b",
                 out_valid, in_ready, m_valid, !m_valid || out_ready);
      end
      if (m_valid || m_pristine) begin
        checks++;
        if ({out_A, out_B, out_ALUctr, out_rd, out_rd_we, out_illegal, out_pc} !== m_cmd) begin
          errors++;
          $display("[TB] FAIL model_cmd: A=%h B=%h ctr=%0d rd=%0d we=%0b ill=%0b pc=%h expected A=%h B=%h ctr=%0d rd=%0d we=%0b ill=%0b pc=%h",
                   out_A, out_B, out_ALUctr, out_rd, out_rd_we, out_illegal, out_pc,
                   m_cmd.a, m_cmd.b, m_cmd.ctr, m_cmd.rd, m_cmd.we, m_cmd.ill, m_cmd.pc);
        end
      end
    end
  end

  // Drive one cycle of inputs and advance just past the rising edge
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] w,
                               input logic [31:0] p, input logic [31:0] a,
                               input logic [31:0] b, input logic f, input logic ordy);
    rst = r; in_valid = v; inst = w; pc = p; rs1_data = a; rs2_data = b;
    flush = f; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs against hand-computed literals
  task automatic checkOutput(input string name, input logic ev, input logic eir,
                             input logic chk_pay, input logic [31:0] ea,
                             input logic [31:0] eb, input logic [3:0] ectr,
                             input logic [4:0] erd, input logic ewe, input logic eill);
    checks++;
    if (out_valid !== ev || in_ready !== eir ||
        (chk_pay && {out_A, out_B, out_ALUctr, out_rd, out_rd_we, out_illegal} !==
                    {ea, eb, ectr, erd, ewe, eill})) begin
      errors++;
      $display("[TB] FAIL %s: v=%0b ir=%0b A=%h B=%h ctr=%0d rd=%0d we=%0b ill=%0b expected v=%0b ir=%0b A=%h B=%h ctr=%0d rd=%0d we=%0b ill=%0b",
               name, out_valid, in_ready, out_A, out_B, out_ALUctr, out_rd, out_rd_we,
               out_illegal, ev, eir, ea, eb, ectr, erd, ewe, eill);
    end
  endtask

  // Pin the reference model itself against literal decodes
  task automatic checkModel(input string name, input cmd_t got, input cmd_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: model=%h expected=%h", name, got, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;

    checkModel("pin_addi", model_decode(32'hFFF00093, 0, 0, 0),
               '{a: 0, b: 32'hFFFFFFFF, ctr: C_ADD, rd: 1, we: 1, ill: 0, pc: 0});
    checkModel("pin_srai", model_decode(32'h40335293, 0, 32'h80000000, 0),
               '{a: 32'h80000000, b: 3, ctr: C_SAR, rd: 5, we: 1, ill: 0, pc: 0});
    checkModel("pin_sw", model_decode(32'h0020A423, 32'h40, 32'h100, 7),
               '{a: 32'h100, b: 8, ctr: C_ADD, rd: 8, we: 0, ill: 0, pc: 32'h40});
    checkModel("pin_bltu", model_decode(32'h0020E063, 0, 9, 2),
               '{a: 9, b: 2, ctr: C_SLTU, rd: 0, we: 0, ill: 0, pc: 0});

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    cmp_en = 1'b1;
    checkOutput("reset_state", 0, 1, 1, 0, 0, C_ADD, 0, 0, 0);

    applyStimulus(0, 1, 32'hFFF00093, 32'h0, 0, 0, 0, 1);
    checkOutput("addi", 1, 1, 1, 0, 32'hFFFFFFFF, C_ADD, 1, 1, 0);

    applyStimulus(0, 1, 32'h40335293, 32'h4, 32'h80000000, 0, 0, 1);
    checkOutput("srai", 1, 1, 1, 32'h80000000, 3, C_SAR, 5, 1, 0);
    applyStimulus(0, 1, 32'h402081B3, 32'h8, 10, 3, 0, 1);
    checkOutput("sub_no_bubble", 1, 1, 1, 10, 3, C_SUB, 3, 1, 0);

    applyStimulus(0, 1, 32'h123453B7, 32'hC, 0, 0, 0, 1);
    checkOutput("lui", 1, 1, 1, 0, 32'h12345000, C_CPB, 7, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'hFFF00093, 32'h10, 0, 0, 0, 0);
      checkOutput("lui_hold", 1, 0, 1, 0, 32'h12345000, C_CPB, 7, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("lui_consumed", 0, 1, 0, 0, 0, C_ADD, 0, 0, 0);

    applyStimulus(0, 1, 32'h00208033, 32'h14, 5, 6, 1, 1);
    checkOutput("flush_drop", 0, 1, 0, 0, 0, C_ADD, 0, 0, 0);
    applyStimulus(0, 1, 32'h00208033, 32'h18, 5, 6, 0, 1);
    checkOutput("add_x0", 1, 1, 1, 5, 6, C_ADD, 0, 0, 0);

    applyStimulus(0, 1, 32'h00000000, 32'h1C, 5, 6, 0, 1);
    checkOutput("zero_illegal", 1, 1, 1, 0, 0, C_ADD, 0, 0, 1);
    applyStimulus(0, 1, 32'h0020A063, 32'h20, 5, 6, 0, 1);
    checkOutput("beq_f3_010", 1, 1, 1, 0, 0, C_ADD, 0, 0, 1);
    applyStimulus(0, 1, 32'h00208063, 32'h24, 5, 6, 0, 1);
    checkOutput("beq", 1, 1, 1, 5, 6, C_SUB, 0, 0, 0);
    applyStimulus(0, 1, 32'h00001217, 32'h100, 0, 0, 0, 1);
    checkOutput("auipc", 1, 1, 1, 32'h100, 32'h1000, C_ADD, 4, 1, 0);
    applyStimulus(0, 1, 32'h008000EF, 32'h200, 0, 0, 0, 1);
    checkOutput("jal", 1, 1, 1, 32'h200, 4, C_ADD, 1, 1, 0);

    // Remaining decodes are checked by the every-cycle model comparison
    applyStimulus(0, 1, 32'hFFC0A283, 32'h204, 32'h1000, 0, 0, 1);
    applyStimulus(0, 1, 32'h0020A423, 32'h208, 32'h1000, 7, 0, 1);
    applyStimulus(0, 1, 32'h40109093, 32'h20C, 1, 0, 0, 1);
    applyStimulus(0, 1, 32'h0020E1B3, 32'h210, 3, 12, 0, 1);
    applyStimulus(0, 1, 32'h00512093, 32'h214, 2, 0, 0, 1);
    applyStimulus(0, 1, 32'h0020E063, 32'h218, 9, 2, 0, 1);
    applyStimulus(0, 1, 32'h4020D0B3, 32'h21C, 32'hF0000000, 4, 0, 1);
    applyStimulus(0, 1, 32'h4020F0B3, 32'h220, 1, 2, 0, 1);
    applyStimulus(0, 1, 32'h00309093, 32'h224, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("flush_held", 0, 1, 0, 0, 0, C_ADD, 0, 0, 0);

    applyStimulus(0, 1, 32'hFFF00093, 32'h300, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_held", 0, 1, 1, 0, 0, C_ADD, 0, 0, 0);
    checks++;
    if (out_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_pc: out_pc=%h expected %h", out_pc, 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
# id_ex_alu_issue

Decode-side issue stage that produces the ALU command for every RV32I instruction: it decodes `inst` into an `ALUctr` code, selects and extends operands A/B, and holds them in the ID/EX pipeline register. It sits between the register-file read in ID and the ALU in EX of the 5-stage core. A valid/ready handshake on both sides supports back-pressure, and a flush input supports branch redirects.

## Interface
- `DATA_WIDTH`, default 32: operand and PC width, equal to `` `DATA_WIDTH `` in define.vh.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  ID holds a decoded-ready instruction.
- `in_ready`  out  1  this stage accepts the instruction this cycle.
- `inst`  in  32  raw instruction word.
- `pc`  in  DATA_WIDTH  PC of `inst`.
- `rs1_data`, `rs2_data`  in  DATA_WIDTH  register-file read data (already forwarded).
- `flush`  in  1  discard the held and incoming instruction.
- `out_valid`  out  1  EX-side command valid.
- `out_ready`  in  1  EX consumes the command this cycle.
- `out_A`, `out_B`  out  DATA_WIDTH  ALU operands.
- `out_ALUctr`  out  4  `` `ALU_CTRL_* `` code from define.vh.
- `out_rd`  out  5  destination register.
- `out_rd_we`  out  1  register write enable.
- `out_pc`  out  DATA_WIDTH  PC of the held instruction.
- `out_illegal`  out  1  the held instruction is not decodable.

## Operation
- Immediates: I = sign-extended `inst[31:20]`; S = sign-extended {`inst[31:25]`,`inst[11:7]`}; U = {`inst[31:12]`, 12'b0}; shamt = zero-extended `inst[24:20]`.
- LUI: A=0, B=U, COPY_B, we=1.
- AUIPC: A=pc, B=U, ADD, we=1.
- JAL, JALR: A=pc, B=4, ADD, we=1 (link value).
- LOAD: A=rs1, B=I, ADD, we=1.
- STORE: A=rs1, B=S, ADD, we=0.
- BRANCH: A=rs1, B=rs2, we=0.
  - BEQ/BNE → SUB (EX uses Zero).
  - BLT/BGE → SLT.
  - BLTU/BGEU → SLTU.
  - funct3 010/011 → illegal.
- OP-IMM: A=rs1, B=I.
  - funct3 000/010/011/100/110/111 → ADD/SLT/SLTU/XOR/OR/AND.
  - 001 → SLL with B=shamt; requires funct7=0000000.
  - 101 → B=shamt; funct7 0000000 gives SLR, 0100000 gives SAR.
- OP: A=rs1, B=rs2.
  - funct7=0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SLR, 110 OR, 111 AND.
  - funct7=0100000: 000 SUB, 101 SAR.
- Illegal: any other opcode/funct3/funct7 combination. Output A=0, B=0, ADD, we=0, illegal=1.
- `out_rd` = `inst[11:7]`. `out_rd_we` is forced to 0 when rd=x0.
- Decode is combinational. Only the registered results appear on outputs.

## Timing
- Reset: `out_valid`=0; `out_A`, `out_B`, `out_pc`, `out_rd`=0; `out_ALUctr`=`` `ALU_CTRL_ADD ``; `out_rd_we`=0; `out_illegal`=0.
- `in_ready` = !`out_valid` || `out_ready` (combinational; single-entry register, no skid buffer).
- Latency: one cycle. A transfer (`in_valid`&&`in_ready`) at edge N presents the command from edge N, valid in cycle N+1.
- Hold: while `out_valid`=1 and `out_ready`=0, every output is stable and `in_ready`=0.
- Simultaneous consume and accept: the held command is replaced with no bubble.
- Consume with no new input: `out_valid`→0. Data outputs hold their last value and are don't-care.
- `flush` has priority over transfer. At the edge `out_valid`→0 and any incoming instruction is dropped. `in_ready` is unaffected.
- `rst` overrides `flush` and transfer.
- Payload registers load only on a transfer.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), rs1_data=0, out_ready=1 → next cycle: out_valid=1, A=0, B=0xFFFFFFFF, ADD, rd=1, we=1.
- SRAI x5,x6,3 (0x40335293), rs1_data=0x80000000 → SAR, A=0x80000000, B=3, rd=5. Then SUB x3,x1,x2 (0x402081B3) back-to-back → SUB on the following cycle, with no bubble.
- LUI x7,0x12345 (0x123453B7) with out_ready=0 for 3 cycles → outputs stable, in_ready=0, and no second instruction accepted. out_ready=1 → consumed, then out_valid=0.
- flush asserted in the same cycle as a transfer of ADD x0,x1,x2 → out_valid=0 next cycle. A separate ADD x0,… that is not flushed → rd_we=0.
- inst=0x00000000 → illegal=1, A=B=0, ADD, we=0. BEQ with funct3=010 → illegal=1.
- rst asserted while a command is held and out_ready=0 → next cycle all outputs are at their reset values and in_ready=1.
